// File: rtl/micro_uart_pkg.sv
// Shared constants for the micro_uart1 receive path and its APB register wrapper.
package micro_uart_pkg;

  localparam int UART_DW              = 8;
  localparam int DEFAULT_DEPTH_LOG2   = 4;
  localparam int DEFAULT_TIMEOUT_BITS = 40;

  // Status register bit positions decoded by the APB wrapper.
  localparam int REC_HAS_DATA = 0;
  localparam int REC_OVERFLOW = 1;
  localparam int TRANS_READY  = 2;
  localparam int RX_TIMEOUT   = 5;
  localparam int RX_THRESH    = 6;

endpackage

// File: rtl/micro_uart1_char_timer.sv
// Counts bit times of line silence while data is pending; pulses expire on the
// tick that brings the count to TIMEOUT_BITS, then holds the count saturated.
module micro_uart1_char_timer #(
  parameter int TIMEOUT_BITS = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic baud_tick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_BITS);

  logic [CW-1:0] count;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIMIT) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (baud_tick) begin
      count <= sat_inc(count);
    end
  end

  // Fires on the tick that completes the silence window, so the sticky flag
  // is visible the cycle right after that tick.
  assign expire = !restart && baud_tick && (count == LIMIT - CW'(1));

endmodule

// File: rtl/micro_uart1_rx_fifo.sv
// Receive FIFO between the UART receiver and the APB wrapper: first-word-fall-through
// byte buffer with level, threshold, sticky overflow and character-timeout status.
module micro_uart1_rx_fifo
  import micro_uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [UART_DW-1:0]   rx_data,
  input  logic                 baud_tick,
  input  logic                 rd_strobe,
  input  logic                 clear,
  input  logic [DEPTH_LOG2:0]  thresh,
  output logic [UART_DW-1:0]   rd_data,
  output logic                 has_data,
  output logic                 full,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overflow,
  output logic                 thresh_hit,
  output logic                 timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [UART_DW-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  expire;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

  // clear outranks both strobes; a pop on a full FIFO frees room for the push.
  assign pop  = rd_strobe && !empty && !clear;
  assign push = rx_valid && !clear && (!full || pop);
  assign drop = rx_valid && !clear && full && !pop;

  assign has_data   = !empty;
  assign rd_data    = empty ? '0 : mem[rd_ptr];
  assign thresh_hit = (thresh != '0) && (level >= thresh);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
      if (push || pop) begin
        timeout <= 1'b0;
      end else if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

  micro_uart1_char_timer #(
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_char_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (push || pop || clear || empty),
    .baud_tick(baud_tick),
    .expire   (expire)
  );

endmodule

// File: tb/tb_micro_uart1_rx_fifo.sv
// Bench for micro_uart1_rx_fifo: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_micro_uart1_rx_fifo;

  localparam int DL    = 4;
  localparam int TB    = 40;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset, rx_valid, baud_tick, rd_strobe, clear;
  logic [7:0]    rx_data;
  logic [DL:0]   thresh;
  logic [7:0]    rd_data;
  logic          has_data, full, overflow, thresh_hit, timeout;
  logic [DL:0]   level;

  always #5 clk = ~clk;

  micro_uart1_rx_fifo #(.DEPTH_LOG2(DL), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .baud_tick(baud_tick), .rd_strobe(rd_strobe), .clear(clear), .thresh(thresh),
    .rd_data(rd_data), .has_data(has_data), .full(full), .level(level),
    .overflow(overflow), .thresh_hit(thresh_hit), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: queue contents, sticky flags, silent bit times.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_tmo;
  int         m_silent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit pop_ok, push_ok, dropped, was_empty;
    if (reset || clear) begin
      q.delete();
      m_ovf = 0; m_tmo = 0; m_silent = 0;
    end else begin
      was_empty = (q.size() == 0);
      pop_ok  = rd_strobe && !was_empty;
      push_ok = rx_valid && (q.size() < DEPTH || pop_ok);
      dropped = rx_valid && !push_ok;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(rx_data);
      if (dropped) m_ovf = 1;
      else if (pop_ok) m_ovf = 0;
      if (push_ok || pop_ok) begin
        m_silent = 0; m_tmo = 0;
      end else if (was_empty) begin
        m_silent = 0;
      end else if (baud_tick) begin
        m_silent++;
        if (m_silent >= TB) begin
          m_silent = TB; m_tmo = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("rd_data",    rd_data,    (q.size() != 0) ? q[0] : 8'h00);
    chk("has_data",   has_data,   q.size() != 0);
    chk("full",       full,       q.size() == DEPTH);
    chk("level",      level,      q.size());
    chk("overflow",   overflow,   m_ovf);
    chk("thresh_hit", thresh_hit, (thresh != 0) && (q.size() >= int'(thresh)));
    chk("timeout",    timeout,    m_tmo);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rd,
                      input logic tk, input logic cl, input logic rs);
    rx_valid = v; rx_data = d; rd_strobe = rd; baud_tick = tk; clear = cl; reset = rs;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [7:0] seq [5];
    seq = '{8'h81, 8'h7E, 8'hFF, 8'h00, 8'hC3};
    reset = 1; rx_valid = 0; rx_data = 0; rd_strobe = 0; baud_tick = 0; clear = 0;
    thresh = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_level", level, 0);
    chk("rst_has_data", has_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_flags", {full, overflow, thresh_hit, timeout}, 0);

    // Ordering through the buffer.
    for (int i = 0; i < 5; i++) step(1, seq[i], 0, 0, 0, 0);
    chk("lvl5", level, 5);
    for (int i = 0; i < 5; i++) begin
      chk("order", rd_data, seq[i]);
      step(0, 0, 1, 0, 0, 0);
    end
    chk("drained", has_data, 0);

    // Overflow drops the newest byte and clears on first pop.
    for (int i = 0; i < 17; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      if (i == 14) chk("not_full15", full, 0);
      if (i == 15) begin
        chk("full16", full, 1);
        chk("no_ovf16", overflow, 0);
      end
    end
    chk("ovf17", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_data", rd_data, 8'(i));
      step(0, 0, 1, 0, 0, 0);
      if (i == 0) chk("ovf_cleared", overflow, 0);
    end

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0, 0);
    chk("pp_full_ovf", overflow, 0);
    chk("pp_full_lvl", level, 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pp_last", rd_data, 8'hAA);
      step(0, 0, 1, 0, 0, 0);
    end

    // Threshold.
    thresh = 3;
    step(1, 8'h01, 0, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0, 0);
    chk("th_2", thresh_hit, 0);
    step(1, 8'h03, 0, 0, 0, 0);
    chk("th_3", thresh_hit, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("th_pop", thresh_hit, 0);
    thresh = 0;
    for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0, 0, 0);
    chk("th_off", thresh_hit, 0);
    step(0, 0, 0, 0, 1, 0);

    // Character timeout.
    step(1, 8'h5A, 0, 0, 0, 0);
    for (int i = 0; i < 39; i++) step(0, 0, 0, 1, 0, 0);
    chk("tmo_39", timeout, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("tmo_40", timeout, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("tmo_pop", timeout, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 0, 0);
    chk("tmo_empty", timeout, 0);

    // clear and reset with a concurrent push.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
      step(1, 8'h55, 0, 0, k == 0, k == 1);
      chk("flush_level", level, 0);
      chk("flush_has", has_data, 0);
      chk("flush_ovf", overflow, 0);
      chk("flush_rd", rd_data, 0);
    end

    // Random traffic in phases with different push/pop/tick densities.
    for (int n = 0; n < 4000; n++) begin
      int ppush, ppop, ptick;
      case (n / 500)
        0: begin ppush = 50; ppop = 20; ptick = 30; end
        1: begin ppush = 20; ppop = 50; ptick = 30; end
        2: begin ppush = 3;  ppop = 2;  ptick = 90; end
        3: begin ppush = 70; ppop = 10; ptick = 10; end
        4: begin ppush = 40; ppop = 40; ptick = 50; end
        default: begin ppush = 5; ppop = 5; ptick = 95; end
      endcase
      if (n % 200 == 0) thresh = (DL + 1)'($urandom_range(DEPTH));
      step($urandom_range(99) < ppush, 8'($urandom),
           $urandom_range(99) < ppop, $urandom_range(99) < ptick,
           $urandom_range(299) == 0, $urandom_range(499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_uart1_rx_fifo.md
Name: micro_uart1_rx_fifo

Overview:
Receive buffer between the micro_uart1 receiver and the APB register wrapper. It replaces the single-byte holding register, which overflows whenever software is one character late. Bytes are pushed on the receiver's load strobe and popped on APB data-register reads. It also provides level, threshold and character-timeout status for interrupt generation.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (16); legal range 2..6.
TIMEOUT_BITS, 40, bit times of line silence with data pending before timeout asserts (4 characters at 10 bits each).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
rx_valid  in  1  one-cycle strobe, receiver has a completed byte.
rx_data  in  8  received byte, valid with rx_valid.
baud_tick  in  1  one-cycle pulse per bit time, from the UART baud divider.
rd_strobe  in  1  one-cycle pop, driven by the APB access phase of a data-register read.
clear  in  1  one-cycle flush of contents and flags.
thresh  in  DEPTH_LOG2+1  level threshold; 0 disables thresh_hit.
rd_data  out  8  head-of-FIFO byte (first-word-fall-through); 8'h00 when empty.
has_data  out  1  level != 0.
full  out  1  level == 2**DEPTH_LOG2.
level  out  DEPTH_LOG2+1  number of bytes stored.
overflow  out  1  sticky, a byte was dropped.
thresh_hit  out  1  (thresh != 0) && (level >= thresh).
timeout  out  1  sticky character-timeout flag.

Behaviour:
- Reset (synchronous, active-high):
  - Pointers, level and timer are 0.
  - overflow = 0, timeout = 0.
  - Therefore rd_data = 0, has_data = 0, full = 0, thresh_hit = 0.
  - The memory array is not reset.
- Storage:
  - Circular buffer with DEPTH_LOG2-bit write and read pointers; both wrap naturally at 2**DEPTH_LOG2.
  - level is held in a separate register, one bit wider than the pointers.
- Push (rx_valid, not full): mem[wr_ptr] <= rx_data; wr_ptr++; level++. Byte is visible on rd_data/has_data the next cycle (latency 1).
- Pop (rd_strobe, level != 0): rd_ptr++; level--. rd_data shows the next byte the following cycle. Pop on empty is ignored and leaves no side effects.
- Push and pop in the same cycle:
  - Not empty: both happen, level unchanged, no overflow, even when full.
  - Empty: push only; the pop is ignored.
- Push while full with no pop: byte is dropped (oldest data is kept), overflow <= 1.
- overflow clear:
  - Cleared by a pop (rd_strobe with level != 0), matching current status-register read-to-clear semantics.
  - If a drop and a pop occur in the same cycle, set wins.
- Character timer (counter wide enough for TIMEOUT_BITS):
  - Counter reset to 0 on any push, pop, clear, or while level == 0.
  - Otherwise increments on baud_tick.
  - When it reaches TIMEOUT_BITS, timeout <= 1 and the counter saturates.
  - timeout is cleared on push, pop or clear. If timeout would set and a push occurs in the same cycle, the push wins (timeout stays 0).
- clear:
  - Pointers, level, timer, overflow and timeout go to 0 next cycle.
  - Has priority over rx_valid and rd_strobe in the same cycle; the simultaneous byte is discarded.
- thresh_hit is combinational from registered level and thresh; there are no other combinational paths from inputs to outputs.
- Reset mid-operation (during a push or pop) behaves exactly as at power-up.

Decomposition:
- Package micro_uart_pkg holds:
  - byte width constant UART_DW = 8.
  - default FIFO depth constant and default timeout constant.
  - status bit positions used by the APB wrapper: REC_HAS_DATA = 0, REC_OVERFLOW = 1, TRANS_READY = 2, RX_TIMEOUT = 5, RX_THRESH = 6.
- One sub-module, micro_uart1_char_timer: the baud_tick counter with restart and saturation, outputting the timeout condition.
- Pointer, level and memory logic stay in the top module.

Test Plan:
- Push 0x81, 0x7E, 0xFF, 0x00, 0xC3 via rx_valid, then pop 5 times -> rd_data sequence is 81, 7E, FF, 00, C3; level goes 5 -> 0; has_data drops after the 5th pop.
- Push 17 bytes 0x00..0x10 with DEPTH_LOG2 = 4 and no pops:
  - full = 1 after 16 pushes, overflow = 1 after the 17th.
  - Popping all 16 yields 0x00..0x0F (0x10 dropped).
  - overflow clears on the first pop.
- Fill to 16, then assert rx_valid (0xAA) and rd_strobe in the same cycle -> overflow stays 0, level stays 16, 0xAA is the last byte read out.
- Push 3 bytes with thresh = 3, then pop one -> thresh_hit is 1 after the 3rd push and 0 after the pop. With thresh = 0 it is never set.
- Push 1 byte, then apply 40 baud_ticks -> timeout = 1 on the cycle after the 40th tick and not before (39 ticks gives 0). A subsequent pop clears it, and with level = 0 the timer never counts.
- Push 5 bytes, assert clear together with rx_valid -> next cycle level = 0, has_data = 0, overflow = 0, rd_data = 0x00. Repeat the sequence with reset instead of clear -> same result.
